// File: rtl/aes_key_pkg.sv
// Shared constants and FSM encoding for the AES key fetch path.
// AES_KEY_CHECKSUM_EN adds a ninth (XOR checksum) word to every fetch.
package aes_key_pkg;

   localparam int KEY_WORDS = 8;
   localparam int WORD_W    = 16;

`ifdef AES_KEY_CHECKSUM_EN
   localparam int NW = KEY_WORDS + 1;
`else
   localparam int NW = KEY_WORDS;
`endif

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/aes_rom_lat_pipe.sv
// Valid/tag delay line matching the key ROM read latency; every stage is visible
// so the parent can tap the return path early and see what is still in flight.
module aes_rom_lat_pipe #(
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_vld,
   input  logic             i_tag,
   output logic [DEPTH-1:0] o_vld,
   output logic [DEPTH-1:0] o_tag
);

   logic [DEPTH-1:0] vld_q, vld_d;
   logic [DEPTH-1:0] tag_q, tag_d;

   always_comb begin
      vld_d = (vld_q << 1) | DEPTH'(i_vld);
      tag_d = (tag_q << 1) | DEPTH'(i_tag);
      if (i_flush) begin
         vld_d = '0;
         tag_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         tag_q <= '0;
      end else begin
         vld_q <= vld_d;
         tag_q <= tag_d;
      end
   end

   assign o_vld = vld_q;
   assign o_tag = tag_q;

endmodule

// File: rtl/aes_key_fetch.sv
// AES key fetch: streams one 128-bit key from the key ROM as eight 16-bit words, MSW first.
// Define AES_KEY_CHECKSUM_EN to also fetch a ninth word and check it against the XOR of the key.
module aes_key_fetch
   import aes_key_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int ROM_LAT    = 1,
   parameter int KEY_BASE   = 0,
   parameter int KEY_STRIDE = 16,
   parameter int KEY_SEL_W  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_time_up,
   input  logic                 i_key_req,
   input  logic [KEY_SEL_W-1:0] i_key_sel,
   output logic                 o_rom_en,
   output logic [ADDR_W-1:0]    o_rom_addr,
   input  logic [15:0]          i_rom_data,
   output logic                 o_key_shift,
   output logic [15:0]          o_data_rom_16bits,
   output logic                 o_done_key,
   output logic                 o_busy,
   output logic                 o_key_err
);

   localparam logic [ROM_LAT-1:0] LAST_BIT = ROM_LAT'(1) << (ROM_LAT - 1);

   function automatic logic [ADDR_W-1:0] key_base(input logic [KEY_SEL_W-1:0] sel);
      return ADDR_W'(KEY_BASE + int'(sel) * KEY_STRIDE);
   endfunction

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WORD_W-1:0]   data_q, data_d;

   logic                issue, last_issue, is_ck, accept, pending;
   logic [ROM_LAT-1:0]  pipe_vld, pipe_tag;
   logic                cap_vld, cap_tag;
   logic                ret_vld, ret_tag;

   assign issue      = (state_q == ISSUE);
   assign last_issue = issue && (cnt_q == CNT_W'(NW - 1));
   assign accept     = (state_q == IDLE) && i_key_req && !i_time_up;

`ifdef AES_KEY_CHECKSUM_EN
   assign is_ck = last_issue;
`else
   assign is_ck = 1'b0;
`endif

   aes_rom_lat_pipe #(
      .DEPTH (ROM_LAT)
   ) u_lat_pipe (
      .clk     (clk),
      .rst     (rst),
      .i_flush (i_time_up),
      .i_vld   (issue),
      .i_tag   (is_ck),
      .o_vld   (pipe_vld),
      .o_tag   (pipe_tag)
   );

   // The output data register is the last cycle of the ROM latency, so capture
   // happens one stage before the tag reaches the end of the delay line.
   generate
      if (ROM_LAT == 1) begin : g_cap_direct
         assign cap_vld = issue;
         assign cap_tag = is_ck;
      end else begin : g_cap_tap
         assign cap_vld = pipe_vld[ROM_LAT-2];
         assign cap_tag = pipe_tag[ROM_LAT-2];
      end
   endgenerate

   assign ret_vld = pipe_vld[ROM_LAT-1];
   assign ret_tag = pipe_tag[ROM_LAT-1];
   assign pending = |(pipe_vld & ~LAST_BIT);

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      cnt_d   = cnt_q;
      if (i_time_up) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_key_req) begin
                  state_d = ISSUE;
                  base_d  = key_base(i_key_sel);
                  cnt_d   = '0;
               end
            end
            ISSUE: begin
               cnt_d = cnt_q + CNT_W'(1);
               if (last_issue) state_d = DRAIN;
            end
            DRAIN: begin
               if (!pending) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      data_d = data_q;
      if (cap_vld && !cap_tag && !i_time_up) data_d = i_rom_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

`ifdef AES_KEY_CHECKSUM_EN
   logic [WORD_W-1:0] xor_q, xor_d;
   logic              mis_q, mis_d;
   logic              err_q, err_d;

   always_comb begin
      xor_d = xor_q;
      mis_d = mis_q;
      err_d = err_q;
      if (i_time_up) begin
         err_d = 1'b0;
      end else if (accept) begin
         xor_d = '0;
         mis_d = 1'b0;
         err_d = 1'b0;
      end else begin
         if (cap_vld) begin
            if (cap_tag) mis_d = (xor_q != i_rom_data);
            else         xor_d = xor_q ^ i_rom_data;
         end
         // Flag lands together with the done pulse and holds until the next fetch.
         if (state_q == DRAIN && state_d == DONE) err_d = mis_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xor_q <= '0;
         mis_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         xor_q <= xor_d;
         mis_q <= mis_d;
         err_q <= err_d;
      end
   end

   assign o_key_err = err_q;
`else
   assign o_key_err = 1'b0;
`endif

   assign o_rom_en          = issue;
   assign o_rom_addr        = base_q + ADDR_W'(cnt_q);
   assign o_key_shift       = ret_vld && !ret_tag;
   assign o_data_rom_16bits = data_q;
   assign o_done_key        = (state_q == DONE);
   assign o_busy            = (state_q != IDLE);

endmodule

// File: tb/tb_aes_key_fetch.sv
// Scoreboard bench for aes_key_fetch: two instances (ROM latency 1 and 3) share one stimulus stream.
`timescale 1ns/1ps
module tb_aes_key_fetch;

   localparam int KEY_BASE   = 0;
   localparam int KEY_STRIDE = 16;
`ifdef AES_KEY_CHECKSUM_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   typedef struct {
      logic [15:0] w;
      int          c;
      int          idx;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       time_up = 1'b0;
   logic       key_req = 1'b0;
   logic [1:0] key_sel = 2'd0;
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;
   logic [15:0] rom_mem [256];
   logic [1:0]  busy_all;
   logic [1:0]  outs_or;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : inst
      localparam int L   = (g == 0) ? 1 : 3;
      localparam int TAP = (L > 1) ? L - 2 : 0;

      logic        rom_en, shift, done, busy, err;
      logic [7:0]  rom_addr;
      logic [15:0] rom_data, dout;
      logic [7:0]  ah [4];
      logic        eh [4];

      aes_key_fetch #(
         .ADDR_W     (8),
         .ROM_LAT    (L),
         .KEY_BASE   (KEY_BASE),
         .KEY_STRIDE (KEY_STRIDE),
         .KEY_SEL_W  (2)
      ) dut (
         .clk               (clk),
         .rst               (rst),
         .i_time_up         (time_up),
         .i_key_req         (key_req),
         .i_key_sel         (key_sel),
         .o_rom_en          (rom_en),
         .o_rom_addr        (rom_addr),
         .i_rom_data        (rom_data),
         .o_key_shift       (shift),
         .o_data_rom_16bits (dout),
         .o_done_key        (done),
         .o_busy            (busy),
         .o_key_err         (err)
      );

      assign busy_all[g] = busy;
      assign outs_or[g]  = rom_en | (|rom_addr) | shift | (|dout) | done | busy | err;

      // ROM: data for a read issued in cycle c is presented during cycle c+L-1
      always @(posedge clk) begin
         if (rst) begin
            eh <= '{default: 1'b0};
         end else begin
            ah[0] <= rom_addr;
            eh[0] <= rom_en;
            for (int i = 1; i < 4; i++) begin
               ah[i] <= ah[i-1];
               eh[i] <= eh[i-1];
            end
         end
      end

      always_comb begin
         rom_data = 16'hDEAD;
         if (L == 1) begin
            if (rom_en) rom_data = rom_mem[rom_addr];
         end else begin
            if (eh[TAP]) rom_data = rom_mem[ah[TAP]];
         end
      end

      // Reference model: timing table and key contents from the ROM image
      exp_t         q[$];
      int           bstart = 0, bend = -1, done_at = -1, mbase = 0;
      int           err_at = 0, err_kill = 0;
      bit           err_val = 1'b0;
      logic [127:0] exp_key = '0;
      logic [15:0]  mx, mw;

      initial forever begin
         @(posedge clk);
         if (rst) begin
            q.delete();
            bend    = -1;
            done_at = -1;
            err_val = 1'b0;
         end else if (time_up) begin
            q.delete();
            if (bend > cyc) bend = cyc;
            done_at  = -1;
            err_kill = cyc + 1;
         end else if (key_req && cyc > bend) begin
            mbase = (KEY_BASE + int'(key_sel) * KEY_STRIDE) % 256;
            mx    = '0;
            for (int i = 0; i < 8; i++) begin
               mw = rom_mem[8'(mbase + i)];
               q.push_back('{w: mw, c: cyc + 1 + L + i, idx: i});
               exp_key = {exp_key[111:0], mw};
               mx = mx ^ mw;
            end
            bstart   = cyc + 1;
            bend     = cyc + 9 + L + EXTRA;
            done_at  = bend;
            err_at   = bend;
            err_kill = 32'h3fff_ffff;
            err_val  = (EXTRA == 1) && (rom_mem[8'(mbase + 8)] != mx);
         end
      end

      // Monitor
      int           nsh = 0;
      logic [127:0] acc = '0;
      exp_t         e;
      bit           exp_b, exp_e, exp_er;

      initial forever begin
         @(negedge clk);
         if (rst) begin
            nsh = 0;
         end else begin
            while (q.size() > 0 && q[0].c < cyc) begin
               n_tests++; n_fail++;
               $display("FAIL inst%0d missing_shift word=%0d due_cycle=%0d now=%0d", g, q[0].idx, q[0].c, cyc);
               void'(q.pop_front());
            end
            if (shift) begin
               n_tests++;
               if (q.size() == 0) begin
                  n_fail++;
                  $display("FAIL inst%0d stray_shift cycle=%0d data=%h expected no shift", g, cyc, dout);
               end else begin
                  e = q.pop_front();
                  if (e.c != cyc || e.w != dout) begin
                     n_fail++;
                     $display("FAIL inst%0d shift_word%0d cycle=%0d data=%h, required cycle=%0d data=%h",
                              g, e.idx, cyc, dout, e.c, e.w);
                  end
                  nsh = (e.idx == 0) ? 1 : nsh + 1;
               end
               acc = {acc[111:0], dout};
            end
            n_tests++;
            if (done != (cyc == done_at)) begin
               n_fail++;
               $display("FAIL inst%0d done_timing cycle=%0d done=%b, required done at cycle %0d", g, cyc, done, done_at);
            end
            if (done) begin
               n_tests++;
               if (acc != exp_key || nsh != 8) begin
                  n_fail++;
                  $display("FAIL inst%0d key got=%h shifts=%0d, required %h shifts=8", g, acc, nsh, exp_key);
               end
            end
            exp_b = (cyc >= bstart) && (cyc <= bend);
            n_tests++;
            if (busy != exp_b) begin
               n_fail++;
               $display("FAIL inst%0d busy cycle=%0d got=%b required=%b", g, cyc, busy, exp_b);
            end
            exp_e = (cyc >= bstart) && (cyc <= bstart + 7 + EXTRA) && (cyc <= bend);
            n_tests++;
            if (rom_en != exp_e || (exp_e && rom_addr != 8'(mbase + cyc - bstart))) begin
               n_fail++;
               $display("FAIL inst%0d rom_en cycle=%0d en=%b addr=%0d, required en=%b addr=%0d",
                        g, cyc, rom_en, rom_addr, exp_e, 8'(mbase + cyc - bstart));
            end
            exp_er = err_val && (cyc >= err_at) && (cyc < err_kill);
            n_tests++;
            if (err != exp_er) begin
               n_fail++;
               $display("FAIL inst%0d key_err cycle=%0d got=%b required=%b", g, cyc, err, exp_er);
            end
         end
      end
   end

   task automatic req(input logic [1:0] sel);
      @(negedge clk);
      key_req = 1'b1;
      key_sel = sel;
      @(negedge clk);
      key_req = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (busy_all != 2'b00 && k < 300);
      @(negedge clk);
      n_tests++;
      if (busy_all != 2'b00) begin
         n_fail++;
         $display("FAIL wait_idle busy=%b after %0d cycles, required 00", busy_all, k);
      end
   endtask

   task automatic check_zero(input string tag);
      for (int g = 0; g < 2; g++) begin
         n_tests++;
         if (outs_or[g] != 1'b0) begin
            n_fail++;
            $display("FAIL %s inst%0d some output nonzero, required all outputs 0", tag, g);
         end
      end
   endtask

   initial begin
      logic [15:0] x;
      for (int a = 0; a < 256; a++) rom_mem[a] = 16'h1000 + 16'(a);
      repeat (2) @(negedge clk);
      check_zero("reset_state");
      @(posedge clk);
      #2 rst = 1'b0;

      // Key 0, then key 2
      req(2'd0);
      wait_idle();
      req(2'd2);
      wait_idle();

      // Abort after the third shift of the latency-1 instance, then a full fetch
      req(2'd1);
      repeat (3) @(negedge clk);
      time_up = 1'b1;
      @(negedge clk);
      time_up = 1'b0;
      repeat (4) @(negedge clk);
      req(2'd1);
      wait_idle();

      // time_up and request together in IDLE: request dropped
      @(negedge clk);
      key_req = 1'b1;
      time_up = 1'b1;
      @(negedge clk);
      key_req = 1'b0;
      time_up = 1'b0;
      repeat (3) @(negedge clk);

      // Request held high for many cycles: back-to-back fetches, extra requests ignored
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         key_req = 1'b1;
         key_sel = 2'($urandom);
      end
      @(negedge clk);
      key_req = 1'b0;
      wait_idle();

      // Randomized ROM image, requests and aborts
      for (int it = 0; it < 6; it++) begin
         for (int a = 0; a < 256; a++) rom_mem[a] = 16'($urandom);
         for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            key_req = ($urandom_range(0, 5) == 0);
            key_sel = 2'($urandom);
            time_up = ($urandom_range(0, 49) == 0);
         end
         @(negedge clk);
         key_req = 1'b0;
         time_up = 1'b0;
         wait_idle();
      end

      // Asynchronous reset in the middle of a fetch
      req(2'd3);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_zero("async_reset");
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (15) @(negedge clk);
      req(2'd0);
      wait_idle();

      // Checksum word correct, then corrupted by one bit
      x = '0;
      for (int i = 0; i < 8; i++) x = x ^ rom_mem[16 + i];
      rom_mem[24] = x;
      req(2'd1);
      wait_idle();
      rom_mem[24] = x ^ 16'h0001;
      req(2'd1);
      wait_idle();

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
